// File: rtl/aes128_key_expand_seq.sv
// aes128_key_expand_seq: sequential AES-128 key schedule with an 11-entry round-key file and registered read port
module aes_sbox (
  input  logic [3:0] hi,
  input  logic [3:0] lo,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction
  logic [7:0] a, x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
  // multiplicative inverse as a^254 in GF(2^8), then the affine map
  always_comb begin
    a    = {hi, lo};
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    inv  = gmul(x252, x2);
    y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes128_key_expand_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic         done,
  output logic [31:0]  rcon_out,
  input  logic [3:0]   rd_addr,
  input  logic         rd_rev,
  output logic [0:127] rd_key,
  output logic         rd_err
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  state_t state, state_d;
  logic [0:127] slot [0:NR];
  logic [3:0] round, s;
  logic [7:0] rc;
  logic [31:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;
  logic err;
  always_comb begin
    {w0, w1, w2, w3} = slot[round - 4'd1];
    rot = {w3[23:0], w3[31:24]};
    t   = sub ^ {rc, 24'h0};
    n0  = t ^ w0;
    n1  = n0 ^ w1;
    n2  = n1 ^ w2;
    n3  = n2 ^ w3;
  end
  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (.hi(rot[8*i+7 -: 4]), .lo(rot[8*i+3 -: 4]), .y(sub[8*i+7 -: 8]));
  end
  always_comb begin
    state_d  = (state == EXPAND) ? ((round == 4'(NR)) ? READY : EXPAND) : (start ? EXPAND : state);
    busy     = state == EXPAND;
    done     = state == READY;
    rcon_out = busy ? {rc, 24'h0} : 32'h0;
    err      = rd_addr > 4'(NR);
    s        = rd_rev ? 4'(NR) - rd_addr : rd_addr;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) slot[i] <= '0;
      round <= '0;
      rc    <= 8'h01;
    end else if (state == EXPAND) begin
      slot[round] <= {n0, n1, n2, n3};
      round       <= round + 4'd1;
      rc          <= rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
    end else if (start) begin
      slot[0] <= key_in;
      round   <= 4'd1;
      rc      <= 8'h01;
    end
  end
  // read data reflects slot contents before any write at the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_key <= '0;
      rd_err <= 1'b0;
    end else begin
      rd_key <= err ? '0 : slot[s];
      rd_err <= err;
    end
  end
endmodule

// File: tb/tb_aes128_key_expand_seq.sv
// tb_aes128_key_expand_seq: random and directed checks against a word-level FIPS-197 key schedule model
module tb_aes128_key_expand_seq;
  logic clk = 0, rst = 1, start = 0, rd_rev = 0;
  logic busy, done, rd_err;
  logic [3:0] rd_addr = 0;
  logic [0:127] key_in = '0;
  logic [0:127] rd_key;
  logic [31:0] rcon_out;
  int checks = 0, errors = 0;
  logic [7:0] sb [0:255];
  logic [7:0] rct [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] rq [$];
  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  aes128_key_expand_seq dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy), .done(done),
    .rcon_out(rcon_out), .rd_addr(rd_addr), .rd_rev(rd_rev), .rd_key(rd_key), .rd_err(rd_err)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] exp_key(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*r+4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rct[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  logic [127:0] m_slot [0:10];
  logic [127:0] m_key = '0, m_rdkey = '0;
  bit m_exp = 0, m_done = 0, m_rderr = 0;
  int m_k = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_slot[i]) m_slot[i] = '0;
      m_exp = 0; m_done = 0; m_k = 0; m_rdkey = '0; m_rderr = 0;
    end else begin
      if (rd_addr > 10) begin
        m_rdkey = '0; m_rderr = 1;
      end else begin
        m_rdkey = m_slot[rd_rev ? 10 - int'(rd_addr) : int'(rd_addr)]; m_rderr = 0;
      end
      if (m_exp) begin
        m_k++;
        m_slot[m_k] = exp_key(m_key, m_k);
        if (m_k == 10) begin m_exp = 0; m_done = 1; end
      end else if (start) begin
        m_key = key_in; m_slot[0] = key_in; m_k = 0; m_exp = 1; m_done = 0;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("busy", busy, m_exp);
    chk("done", done, m_done);
    chk("rcon", rcon_out, m_exp ? {rct[m_k], 24'h0} : 32'h0);
    chk("rd_key", rd_key, m_rdkey);
    chk("rd_err", rd_err, m_rderr);
  end

  task automatic do_start(input logic [127:0] k);
    @(negedge clk); key_in = k; start = 1;
    @(negedge clk); start = 0; key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(output int n);
    rq.delete();
    n = 0;
    while (!done && n < 30) begin
      if (busy) rq.push_back(rcon_out);
      @(negedge clk); n++;
    end
  endtask

  task automatic rd(input logic [3:0] a, input bit rev, output logic [127:0] q, output logic e);
    @(negedge clk); rd_addr = a; rd_rev = rev;
    @(negedge clk); q = rd_key; e = rd_err;
  endtask

  initial begin
    logic [7:0] p, q8;
    logic [127:0] kq, ka, kb;
    logic e;
    int n;
    p = 1; q8 = 1;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q8 ^= {q8[6:0], 1'b0}; q8 ^= {q8[5:0], 2'b0}; q8 ^= {q8[3:0], 4'b0};
      if (q8[7]) q8 ^= 8'h09;
      sb[p] = q8 ^ {q8[6:0], q8[7]} ^ {q8[5:0], q8[7:6]} ^ {q8[4:0], q8[7:5]} ^ {q8[3:0], q8[7:4]} ^ 8'h63;
    end while (p != 1);
    sb[0] = 8'h63;
    chk("model_fips_k1", exp_key(FIPS, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_zero_k10", exp_key(0, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rcon", rcon_out, 0);
    chk("rst_rd_key", rd_key, 0); chk("rst_rd_err", rd_err, 0);
    rst = 0;
    // FIPS-197 forward reads, latency and rcon sequence
    do_start(FIPS);
    wait_done(n);
    chk("done_latency", n, 10);
    chk("rcon_count", rq.size(), 10);
    for (int i = 0; i < 10 && i < rq.size(); i++) chk($sformatf("rcon_%0d", i), rq[i], {rct[i], 24'h0});
    chk("rcon_idle", rcon_out, 0);
    rd(1, 0, kq, e); chk("fips_k1", kq, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(2, 0, kq, e); chk("fips_k2", kq, 128'hf2c295f27a96b9435935807a7359f67f);
    rd(10, 0, kq, e); chk("fips_k10", kq, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    // zero key reverse reads
    do_start(0);
    wait_done(n);
    rd(0, 1, kq, e); chk("zero_rev0", kq, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    rd(9, 1, kq, e); chk("zero_rev9", kq, 128'h62636363626363636263636362636363);
    // start during expansion is ignored
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    do_start(ka);
    repeat (3) @(negedge clk);
    start = 1; key_in = kb;
    @(negedge clk); start = 0;
    wait_done(n);
    chk("ignored_start_latency", n, 6);
    rd(10, 0, kq, e); chk("ignored_start_k10", kq, exp_key(ka, 10));
    // restart from READY
    do_start(kb);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    wait_done(n);
    chk("restart_latency", n, 10);
    rd(0, 0, kq, e);
    // async reset mid-expansion
    do_start(ka);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst = 1;
    #1;
    chk("midrst_busy", busy, 0); chk("midrst_done", done, 0); chk("midrst_rd_key", rd_key, 0);
    @(negedge clk); rst = 0;
    repeat (12) @(negedge clk);
    chk("midrst_stays_undone", done, 0);
    // out-of-range reads
    do_start(FIPS);
    wait_done(n);
    rd(11, 0, kq, e); chk("oor11_key", kq, 0); chk("oor11_err", e, 1);
    rd(15, 1, kq, e); chk("oor15_key", kq, 0); chk("oor15_err", e, 1);
    rd(10, 0, kq, e); chk("addr10_key", kq, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6); chk("addr10_err", e, 0);
    // random traffic against the model
    repeat (400) begin
      @(negedge clk);
      rd_addr = 4'($urandom_range(0, 15));
      rd_rev = 1'($urandom);
      start = ($urandom_range(0, 19) == 0);
      key_in = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk); start = 0;
    repeat (12) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
